// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage ARM-subset core.
// Optional macro IF_PERF_COUNTERS_EN adds saturating fetch/stall/flush event counters.
module if_stage_pipe #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard_Detected,
  input  logic              mem_freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_instr,
`ifdef IF_PERF_COUNTERS_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush,
`endif
  output logic              id_valid
);

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] pc_r, pc_next_s;
  logic [ADDR_W-1:0] id_pc_r, id_pc_next_s;
  logic [31:0]       id_instr_r, id_instr_next_s;
  logic              id_valid_r, id_valid_next_s;
  logic              fetch_s, stall_s, flush_s;

  assign imem_addr = pc_r;
  assign imem_req  = ~rst & ~mem_freeze & ~hazard_Detected & ~branch_taken;
  assign id_pc     = id_pc_r;
  assign id_instr  = id_instr_r;
  // A redirect cycle never presents a valid instruction, even if the register were upset.
  assign id_valid  = id_valid_r & (state_r != ST_REDIRECT);

  // Priority resolution: freeze > branch > hazard > memory not ready > normal fetch.
  always_comb begin
    pc_next_s       = pc_r;
    id_pc_next_s    = id_pc_r;
    id_instr_next_s = id_instr_r;
    id_valid_next_s = id_valid_r;
    state_next_s    = ST_FETCH;
    fetch_s         = 1'b0;
    stall_s         = 1'b0;
    flush_s         = 1'b0;
    if (mem_freeze) begin
      state_next_s = ST_STALL;
      stall_s      = 1'b1;
    end else if (branch_taken) begin
      pc_next_s       = branch_addr;
      id_pc_next_s    = {ADDR_W{1'b0}};
      id_instr_next_s = NOP_INSTR;
      id_valid_next_s = 1'b0;
      state_next_s    = ST_REDIRECT;
      flush_s         = 1'b1;
    end else if (hazard_Detected) begin
      state_next_s = ST_STALL;
      stall_s      = 1'b1;
    end else if (!imem_ready) begin
      id_pc_next_s    = {ADDR_W{1'b0}};
      id_instr_next_s = NOP_INSTR;
      id_valid_next_s = 1'b0;
      state_next_s    = ST_STALL;
      stall_s         = 1'b1;
    end else begin
      pc_next_s       = pc_r + PC_STEP;
      id_pc_next_s    = pc_r + PC_STEP;
      id_instr_next_s = imem_rdata;
      id_valid_next_s = 1'b1;
      state_next_s    = ST_FETCH;
      fetch_s         = 1'b1;
    end
  end

  // PC, IF/ID register and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      id_pc_r    <= {ADDR_W{1'b0}};
      id_instr_r <= NOP_INSTR;
      id_valid_r <= 1'b0;
      state_r    <= ST_FETCH;
    end else begin
      pc_r       <= pc_next_s;
      id_pc_r    <= id_pc_next_s;
      id_instr_r <= id_instr_next_s;
      id_valid_r <= id_valid_next_s;
      case (state_next_s)
        ST_FETCH:    state_r <= ST_FETCH;
        ST_STALL:    state_r <= ST_STALL;
        ST_REDIRECT: state_r <= ST_REDIRECT;
        default:     state_r <= ST_FETCH;
      endcase
    end
  end

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_r, perf_stall_r, perf_flush_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) sat_inc = v;
    else                    sat_inc = v + 32'd1;
  endfunction

  assign perf_fetched = perf_fetched_r;
  assign perf_stall   = perf_stall_r;
  assign perf_flush   = perf_flush_r;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_r <= 32'd0;
      perf_stall_r   <= 32'd0;
      perf_flush_r   <= 32'd0;
    end else begin
      if (fetch_s) perf_fetched_r <= sat_inc(perf_fetched_r);
      if (stall_s) perf_stall_r   <= sat_inc(perf_stall_r);
      if (flush_s) perf_flush_r   <= sat_inc(perf_flush_r);
    end
  end
`else
  logic unused_events_s;
  assign unused_events_s = fetch_s ^ stall_s ^ flush_s;
`endif

endmodule
